store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Posted-write buffer between the MEM pipeline stage and the word-addressed data memory, which has a combinational read and writes on posedge clk.
- Queues CPU stores in a small FIFO and drains one per cycle into memory.
- Forwards buffered data to later loads to the same word.
- Removes store/load port conflicts from the pipeline; asserts stall only when it cannot proceed.

Parameters:
- DEPTH, 4, number of buffered stores (power of two, ≥2).
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; clears the buffer.
- cpu_rd  in  1  MEM-stage load request.
- cpu_wr  in  1  MEM-stage store request.
- cpu_addr  in  32  byte address, word aligned; bits [1:0] ignored.
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load result, combinational.
- stall  out  1  combinational; MEM stage must hold its request while 1.
- sync  in  1  barrier/halt request; buffer must empty before sync retires.
- mem_hold  in  1  memory port reserved by another master this cycle.
- mem_rd  out  1  memory read enable.
- mem_wr  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data (combinational from address).
- empty  out  1  no entries valid.
- full  out  1  DEPTH entries valid.
- count  out  PTR_W+1  number of valid entries.

Behaviour:
- Reset (reset=0, async): head, tail and count cleared; all valid bits cleared. Stored addr/data are don't-care.
  - Outputs with inputs idle: empty=1, full=0, count=0, mem_rd=0, mem_wr=0, cpu_rdata=0, stall=0.
  - Reset mid-drain discards all pending stores. No partial write results, because the memory write occurs only on a clk edge.
- Storage: circular FIFO of {word address [31:2], data}. Enqueue at tail, dequeue at head. Pointers wrap modulo DEPTH.
- Hit detection (combinational): compare cpu_addr[31:2] against every valid entry.
  - hit = any match.
  - On multiple matches, the youngest (closest to tail) supplies fwd_data.
- Load miss: miss_rd = cpu_rd & !hit.
- Drain condition: drain = !empty & !mem_hold & !miss_rd. Loads that miss have priority over draining.
- Memory port:
  - If miss_rd & !mem_hold: mem_rd=1, mem_addr=cpu_addr, mem_wr=0.
  - Else if drain: mem_wr=1, mem_addr={head addr,2'b00}, mem_wdata=head data, mem_rd=0.
  - Else mem_rd=mem_wr=0, mem_addr=0, mem_wdata=0.
- cpu_rdata:
  - cpu_rd & hit: fwd_data; memory not accessed.
  - cpu_rd & !hit: mem_rdata.
  - Otherwise 0.
- Load latency is 0 cycles (same-cycle result). A store is visible to forwarding from the cycle after acceptance.
- Store acceptance: accept = cpu_wr & !stall. Entry written at tail on the next posedge; tail increments.
  - Full with a simultaneous drain: push and pop in the same cycle, so the store is accepted and count is unchanged.
- stall = (cpu_wr & full & !drain) | (cpu_rd & !hit & mem_hold) | (sync & !empty).
  - During sync, stall persists until empty=1.
  - sync with empty=1 gives stall=0.
- Count update: count_next = count + accept − drain. full = (count==DEPTH). empty = (count==0).
- cpu_rd and cpu_wr asserted together is illegal. The buffer treats it as a store and suppresses hit/miss_rd, so cpu_rdata=0.
- The buffer is address-agnostic. Out-of-range addresses are buffered, forwarded and drained like any other; the memory discards them.
- Drain order is strictly FIFO. Two stores to the same word both drain, oldest first.

Test Plan:
- Reset with 3 entries queued -> next cycle count=0, empty=1, mem_wr=0. A load of a previously buffered address returns mem_rdata, not stale data.
- Stores A=0x10←0x11111111, B=0x14←0x22222222 on consecutive cycles, mem_hold=0 -> mem_wr pulses with addr 0x10 then 0x14. Memory later reads back those values. empty=1 after 2 drain cycles.
- mem_hold=1, stores 0x20←1, 0x20←2, then load 0x20 -> cpu_rdata=2 (youngest), mem_rd=0, stall=0.
- mem_hold=1, 4 stores fill the buffer (full=1); 5th store -> stall=1, count=4. Release mem_hold -> drain and 5th store accepted in the same cycle, count stays 4, stall=0.
- Buffer holds 2 entries, load to non-matching 0x40 with mem_hold=0 -> mem_rd=1, mem_addr=0x40, mem_wr=0 that cycle. Drain resumes the following cycle.
- sync=1 with count=3, mem_hold=0 -> stall=1 for exactly 3 cycles, then 0 with empty=1.

Source files
------------

// File: rtl/store_buffer.sv
// Posted-write store buffer sitting between the MEM stage and a word-addressed data memory.
// Queues stores in a circular FIFO, drains one per idle memory cycle and forwards to matching loads.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_rd,
    input  logic             cpu_wr,
    input  logic [31:0]      cpu_addr,
    input  logic [31:0]      cpu_wdata,
    output logic [31:0]      cpu_rdata,
    output logic             stall,
    input  logic             sync,
    input  logic             mem_hold,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    output logic             empty,
    output logic             full,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] LP_FULL = (PTR_W+1)'(DEPTH);

    logic [29:0]        r_addr [DEPTH];
    logic [31:0]        r_data [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [PTR_W:0]     r_count;

    logic               w_rdEff;
    logic               w_hit;
    logic [31:0]        w_fwdData;
    logic [PTR_W-1:0]   w_idx;
    logic               w_missRd;
    logic               w_drain;
    logic               w_accept;
    logic               w_empty;
    logic               w_full;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == LP_FULL);

    // A simultaneous load and store is treated purely as a store.
    assign w_rdEff = cpu_rd & ~cpu_wr;

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        w_hit     = 1'b0;
        w_fwdData = '0;
        w_idx     = r_head;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PTR_W'(i);
            if (((PTR_W+1)'(i) < r_count) && (r_addr[w_idx] == cpu_addr[31:2])) begin
                w_hit     = 1'b1;
                w_fwdData = r_data[w_idx];
            end
        end
    end

    assign w_missRd = w_rdEff & ~w_hit;
    assign w_drain  = ~w_empty & ~mem_hold & ~w_missRd;
    assign stall    = (cpu_wr & w_full & ~w_drain) | (w_missRd & mem_hold) | (sync & ~w_empty);
    assign w_accept = cpu_wr & ~stall;

    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_missRd && !mem_hold) begin
            mem_rd   = 1'b1;
            mem_addr = cpu_addr;
        end else if (w_drain) begin
            mem_wr    = 1'b1;
            mem_addr  = {r_addr[r_head], 2'b00};
            mem_wdata = r_data[r_head];
        end
    end

    always_comb begin
        cpu_rdata = '0;
        if (w_rdEff) begin
            cpu_rdata = w_hit ? w_fwdData : mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_drain) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_accept, w_drain})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr[r_tail] <= cpu_addr[31:2];
            r_data[r_tail] <= cpu_wdata;
        end
    end

    assign empty = w_empty;
    assign full  = w_full;
    assign count = r_count;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a small combinational-read data memory model.
module tb_store_buffer;

    logic        clk;
    logic        reset;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        sync;
    logic        mem_hold;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        empty;
    logic        full;
    logic [2:0]  count;

    logic [31:0] memArray [256];
    int compareCount;
    int mismatchCount;
    int stallCycles;

    store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .stall(stall), .sync(sync), .mem_hold(mem_hold),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .empty(empty), .full(full), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-addressed memory: combinational read, write on the rising edge.
    assign mem_rdata = memArray[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_wr) memArray[mem_addr[9:2]] <= mem_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic hold, input logic syn);
        cpu_rd    = rd;
        cpu_wr    = wr;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        mem_hold  = hold;
        sync      = syn;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        for (int i = 0; i < 256; i++) memArray[i] = 32'hDEAD0000 | 32'(i);
        reset = 1'b0;
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 0);
        #2;
        checkOutput("rstEmpty", 32'(empty), 32'd1);
        checkOutput("rstFull", 32'(full), 32'd0);
        checkOutput("rstCount", 32'(count), 32'd0);
        checkOutput("rstMemRd", 32'(mem_rd), 32'd0);
        checkOutput("rstMemWr", 32'(mem_wr), 32'd0);
        checkOutput("rstRdata", cpu_rdata, 32'd0);
        checkOutput("rstStall", 32'(stall), 32'd0);
        checkOutput("rstWdata", mem_wdata, 32'd0);
        #3 reset = 1'b1;

        // Two consecutive stores drain in order while the second is being accepted.
        tick();
        applyStimulus(0, 1, 32'h10, 32'h11111111, 0, 0);
        checkOutput("stA.stall", 32'(stall), 32'd0);
        checkOutput("stA.memWr", 32'(mem_wr), 32'd0);
        tick();
        applyStimulus(0, 1, 32'h14, 32'h22222222, 0, 0);
        checkOutput("stB.count", 32'(count), 32'd1);
        checkOutput("drA.memWr", 32'(mem_wr), 32'd1);
        checkOutput("drA.addr", mem_addr, 32'h10);
        checkOutput("drA.data", mem_wdata, 32'h11111111);
        tick();
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 0);
        checkOutput("drB.memWr", 32'(mem_wr), 32'd1);
        checkOutput("drB.addr", mem_addr, 32'h14);
        checkOutput("drB.data", mem_wdata, 32'h22222222);
        tick();
        checkOutput("drained.empty", 32'(empty), 32'd1);
        applyStimulus(1, 0, 32'h10, 32'h0, 0, 0);
        checkOutput("ldA.memRd", 32'(mem_rd), 32'd1);
        checkOutput("ldA.data", cpu_rdata, 32'h11111111);
        applyStimulus(1, 0, 32'h14, 32'h0, 0, 0);
        checkOutput("ldB.data", cpu_rdata, 32'h22222222);

        // Same-word stores under hold: the younger one forwards.
        tick();
        applyStimulus(0, 1, 32'h20, 32'd1, 1, 0);
        tick();
        applyStimulus(0, 1, 32'h20, 32'd2, 1, 0);
        tick();
        applyStimulus(1, 0, 32'h20, 32'h0, 1, 0);
        checkOutput("fwd.data", cpu_rdata, 32'd2);
        checkOutput("fwd.memRd", 32'(mem_rd), 32'd0);
        checkOutput("fwd.stall", 32'(stall), 32'd0);
        checkOutput("fwd.count", 32'(count), 32'd2);
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 0);
        tick();
        tick();
        checkOutput("fwdDrain.empty", 32'(empty), 32'd1);
        applyStimulus(1, 0, 32'h20, 32'h0, 0, 0);
        checkOutput("fwdOrder.mem", cpu_rdata, 32'd2);

        // Fill under hold, then push and pop together on release.
        tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 32'h30 + 32'(4 * i), 32'hA0 + 32'(i), 1, 0);
            tick();
        end
        applyStimulus(0, 1, 32'h50, 32'hA4, 1, 0);
        checkOutput("full.full", 32'(full), 32'd1);
        checkOutput("full.count", 32'(count), 32'd4);
        checkOutput("full.stall", 32'(stall), 32'd1);
        tick();
        checkOutput("fullHeld.count", 32'(count), 32'd4);
        applyStimulus(0, 1, 32'h50, 32'hA4, 0, 0);
        checkOutput("pushPop.stall", 32'(stall), 32'd0);
        checkOutput("pushPop.memWr", 32'(mem_wr), 32'd1);
        checkOutput("pushPop.addr", mem_addr, 32'h30);
        tick();
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 0);
        checkOutput("pushPop.count", 32'(count), 32'd4);
        checkOutput("pushPop.full", 32'(full), 32'd1);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("fullDrain.empty", 32'(empty), 32'd1);
        applyStimulus(1, 0, 32'h50, 32'h0, 0, 0);
        checkOutput("fullDrain.ld50", cpu_rdata, 32'hA4);
        applyStimulus(1, 0, 32'h3C, 32'h0, 0, 0);
        checkOutput("fullDrain.ld3C", cpu_rdata, 32'hA3);

        // A missing load takes the port ahead of draining.
        tick();
        applyStimulus(0, 1, 32'h60, 32'h66, 1, 0);
        tick();
        applyStimulus(0, 1, 32'h64, 32'h77, 1, 0);
        tick();
        applyStimulus(1, 0, 32'h40, 32'h0, 0, 0);
        checkOutput("miss.memRd", 32'(mem_rd), 32'd1);
        checkOutput("miss.memWr", 32'(mem_wr), 32'd0);
        checkOutput("miss.addr", mem_addr, 32'h40);
        checkOutput("miss.data", cpu_rdata, 32'hDEAD0010);
        tick();
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 0);
        checkOutput("missAfter.count", 32'(count), 32'd2);
        checkOutput("missAfter.memWr", 32'(mem_wr), 32'd1);
        checkOutput("missAfter.addr", mem_addr, 32'h60);
        tick();
        tick();

        // Sync with three entries stalls exactly while they drain.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 32'h70 + 32'(4 * i), 32'hC0 + 32'(i), 1, 0);
            tick();
        end
        checkOutput("sync.count", 32'(count), 32'd3);
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 1);
        stallCycles = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (!stall) break;
            stallCycles++;
            tick();
        end
        checkOutput("sync.stallCycles", 32'(stallCycles), 32'd3);
        checkOutput("sync.empty", 32'(empty), 32'd1);
        checkOutput("sync.stallEnd", 32'(stall), 32'd0);

        // Asynchronous reset discards queued stores.
        applyStimulus(0, 0, 32'h0, 32'h0, 1, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 32'h80 + 32'(4 * i), 32'hBAD0 + 32'(i), 1, 0);
            tick();
        end
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 0);
        checkOutput("preRst.count", 32'(count), 32'd3);
        reset = 1'b0;
        #1;
        checkOutput("midRst.count", 32'(count), 32'd0);
        checkOutput("midRst.empty", 32'(empty), 32'd1);
        checkOutput("midRst.memWr", 32'(mem_wr), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        applyStimulus(1, 0, 32'h80, 32'h0, 0, 0);
        checkOutput("postRst.memRd", 32'(mem_rd), 32'd1);
        checkOutput("postRst.data", cpu_rdata, 32'hDEAD0020);

        // Simultaneous load and store behaves as a store only.
        tick();
        applyStimulus(0, 1, 32'h90, 32'h99, 1, 0);
        tick();
        applyStimulus(1, 1, 32'h90, 32'h9A, 1, 0);
        checkOutput("rdwr.rdata", cpu_rdata, 32'd0);
        checkOutput("rdwr.memRd", 32'(mem_rd), 32'd0);
        tick();
        applyStimulus(1, 0, 32'h90, 32'h0, 1, 0);
        checkOutput("rdwr.count", 32'(count), 32'd2);
        checkOutput("rdwr.fwd", cpu_rdata, 32'h9A);
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 0);
        tick();
        tick();
        checkOutput("final.empty", 32'(empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
